// File: rtl/coin_bank.sv
// coin_bank: synchronises a raw coin strobe, accumulates coin value as credit and banks games.
// Latency: coin rising before edge E shows in credit after E+2; first game converted after E+3.
// Flow: no backpressure; credit saturates at CMAX (coinLost), conversion stalls at MAX_GAMES.
// Optional refund path enabled by defining COIN_REFUND_EN.
module coin_bank #(
    parameter int PRICE     = 4,
    parameter int MAX_GAMES = 7,
    parameter int GAME_W    = 4,
    parameter int CREDIT_W  = 4,
    parameter int VAL0      = 4,
    parameter int VAL1      = 1,
    parameter int VAL2      = 3,
    parameter int VAL3      = 5
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic                CoinInserted,
    input  logic [1:0]          CoinValue,
    input  logic                startGameNow,
    input  logic                masterLoaded,
    input  logic                gamePlaying,
`ifdef COIN_REFUND_EN
    input  logic                refundReq,
    output logic                refundValid,
    output logic [CREDIT_W-1:0] refundAmt,
`endif
    output logic [GAME_W-1:0]   NumGames,
    output logic [CREDIT_W-1:0] credit,
    output logic                ready,
    output logic                gameTaken,
    output logic                coinLost
);

    // Arithmetic is done one bit wider than credit so clipping can be detected.
    localparam logic [CREDIT_W:0]   CMAX_W  = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [CREDIT_W:0]   PRICE_W = (CREDIT_W+1)'(PRICE);
    localparam logic [GAME_W-1:0]   MAX_G   = GAME_W'(MAX_GAMES);

    typedef enum logic {IDLE = 1'b0, CONVERT = 1'b1} state_t;

    function automatic logic [CREDIT_W:0] coin_units(input logic [1:0] code);
        case (code)
            2'd0:    coin_units = (CREDIT_W+1)'(VAL0);
            2'd1:    coin_units = (CREDIT_W+1)'(VAL1);
            2'd2:    coin_units = (CREDIT_W+1)'(VAL2);
            default: coin_units = (CREDIT_W+1)'(VAL3);
        endcase
    endfunction

    logic                s1_q, s2_q, s3_q;
    logic [1:0]          v1_q, v2_q;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [GAME_W-1:0]   num_games_q, num_games_d;
    logic                game_taken_q, game_taken_d;
    logic                coin_lost_q, coin_lost_d;
    state_t              state_q, state_d;

    logic                coin_evt;
    logic [CREDIT_W:0]   coin_val;
    logic [CREDIT_W:0]   sum;
    logic                conv_ok;
    logic                conv;
    logic                take;
    logic                refund_cycle;

`ifdef COIN_REFUND_EN
    logic                refund_valid_q, refund_valid_d;
    logic [CREDIT_W-1:0] refund_amt_q, refund_amt_d;
    assign refund_cycle = refundReq;
`else
    assign refund_cycle = 1'b0;
`endif

    // The value code travels alongside the strobe so it lines up with the detected edge.
    assign coin_evt = s2_q & ~s3_q;
    assign coin_val = coin_evt ? coin_units(v2_q) : '0;

    assign ready   = (num_games_q != '0) & masterLoaded & ~gamePlaying;
    assign take    = startGameNow & ready;
    // Credit is tested before this cycle's coin is added.
    assign conv_ok = ({1'b0, credit_q} >= PRICE_W) & (num_games_q < MAX_G) & ~refund_cycle;

    // Conversion FSM: one game per cycle while conversion is possible.
    always_comb begin
        state_d = state_q;
        conv    = 1'b0;
        case (state_q)
            IDLE: begin
                conv = conv_ok;
                if (conv_ok) state_d = CONVERT;
            end
            CONVERT: begin
                conv = conv_ok;
                if (!conv_ok) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Credit/game bookkeeping with saturation at CMAX.
    always_comb begin
        sum          = {1'b0, credit_q} + coin_val - (conv ? PRICE_W : '0);
        credit_d     = credit_q;
        coin_lost_d  = 1'b0;
        num_games_d  = num_games_q + GAME_W'(conv) - GAME_W'(take);
        game_taken_d = take;
`ifdef COIN_REFUND_EN
        refund_valid_d = 1'b0;
        refund_amt_d   = refund_amt_q;
`endif
        if (refund_cycle) begin
            // A coin landing in the refund cycle becomes the new credit.
            credit_d = coin_val[CREDIT_W-1:0];
`ifdef COIN_REFUND_EN
            refund_valid_d = 1'b1;
            refund_amt_d   = credit_q;
`endif
        end else if (sum > CMAX_W) begin
            credit_d    = CMAX_W[CREDIT_W-1:0];
            coin_lost_d = 1'b1;
        end else begin
            credit_d = sum[CREDIT_W-1:0];
        end
    end

    // Coin strobe synchroniser and value pipeline.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
            v1_q <= 2'd0;
            v2_q <= 2'd0;
        end else begin
            s1_q <= CoinInserted;
            s2_q <= s1_q;
            s3_q <= s2_q;
            v1_q <= CoinValue;
            v2_q <= v1_q;
        end
    end

    // Bank state registers and output pulses.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            credit_q     <= '0;
            num_games_q  <= '0;
            game_taken_q <= 1'b0;
            coin_lost_q  <= 1'b0;
            state_q      <= IDLE;
        end else begin
            credit_q     <= credit_d;
            num_games_q  <= num_games_d;
            game_taken_q <= game_taken_d;
            coin_lost_q  <= coin_lost_d;
            state_q      <= state_d;
        end
    end

`ifdef COIN_REFUND_EN
    // Refund result registers; amount is held until the next refund.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            refund_valid_q <= 1'b0;
            refund_amt_q   <= '0;
        end else begin
            refund_valid_q <= refund_valid_d;
            refund_amt_q   <= refund_amt_d;
        end
    end

    assign refundValid = refund_valid_q;
    assign refundAmt   = refund_amt_q;
`endif

    assign NumGames  = num_games_q;
    assign credit    = credit_q;
    assign gameTaken = game_taken_q;
    assign coinLost  = coin_lost_q;

endmodule

// File: tb/tb_coin_bank.sv
// Bench for coin_bank with default parameters: cycle table with expected outputs queued
// at drive time and compared one clock later, plus reset-mid-conversion and refund sequences.
module tb_coin_bank;

    logic       CLOCK_50;
    logic       reset;
    logic       CoinInserted;
    logic [1:0] CoinValue;
    logic       startGameNow;
    logic       masterLoaded;
    logic       gamePlaying;
    logic [3:0] NumGames;
    logic [3:0] credit;
    logic       ready;
    logic       gameTaken;
    logic       coinLost;
`ifdef COIN_REFUND_EN
    logic       refundReq;
    logic       refundValid;
    logic [3:0] refundAmt;
`endif

    coin_bank dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
        .CoinInserted (CoinInserted),
        .CoinValue    (CoinValue),
        .startGameNow (startGameNow),
        .masterLoaded (masterLoaded),
        .gamePlaying  (gamePlaying),
`ifdef COIN_REFUND_EN
        .refundReq    (refundReq),
        .refundValid  (refundValid),
        .refundAmt    (refundAmt),
`endif
        .NumGames     (NumGames),
        .credit       (credit),
        .ready        (ready),
        .gameTaken    (gameTaken),
        .coinLost     (coinLost)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        logic       coin;
        logic [1:0] code;
        logic       start;
        logic       ml;
        logic       gp;
        logic       refund;
        int         ng;
        int         cr;
        logic       tk;
        logic       lost;
    } vec_t;

    vec_t tbl[$];
    vec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mk(logic coin, logic [1:0] code, logic start, logic ml, logic gp,
                                logic refund, int ng, int cr, logic tk, logic lost);
        vec_t v;
        v.coin = coin; v.code = code; v.start = start; v.ml = ml; v.gp = gp;
        v.refund = refund; v.ng = ng; v.cr = cr; v.tk = tk; v.lost = lost;
        return v;
    endfunction

    // Common row: masterLoaded high, no game playing, no refund.
    function automatic vec_t r(logic coin, logic [1:0] code, logic start, int ng, int cr,
                               logic tk, logic lost);
        return mk(coin, code, start, 1'b1, 1'b0, 1'b0, ng, cr, tk, lost);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Drive one cycle of inputs at a falling edge, then compare after the rising edge.
    task automatic apply(input vec_t v, input string nm);
        vec_t e;
        CoinInserted = v.coin;
        CoinValue    = v.code;
        startGameNow = v.start;
        masterLoaded = v.ml;
        gamePlaying  = v.gp;
`ifdef COIN_REFUND_EN
        refundReq    = v.refund;
`endif
        exp_q.push_back(v);
        @(negedge CLOCK_50);
        if (exp_q.size() == 0) begin
            chk({nm, ".queue"}, 0, 1);
        end else begin
            e = exp_q.pop_front();
            chk({nm, ".NumGames"},  int'(NumGames),  e.ng);
            chk({nm, ".credit"},    int'(credit),    e.cr);
            chk({nm, ".gameTaken"}, int'(gameTaken), int'(e.tk));
            chk({nm, ".coinLost"},  int'(coinLost),  int'(e.lost));
            chk({nm, ".ready"},     int'(ready),     int'((e.ng != 0) && e.ml && !e.gp));
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, ".NumGames"},  int'(NumGames),  0);
        chk({nm, ".credit"},    int'(credit),    0);
        chk({nm, ".gameTaken"}, int'(gameTaken), 0);
        chk({nm, ".coinLost"},  int'(coinLost),  0);
        chk({nm, ".ready"},     int'(ready),     0);
`ifdef COIN_REFUND_EN
        chk({nm, ".refundValid"}, int'(refundValid), 0);
        chk({nm, ".refundAmt"},   int'(refundAmt),   0);
`endif
    endtask

    initial begin
        // Four code-1 coins (one unit each), then conversion of the fourth unit.
        tbl.push_back(r(1,1,0, 0,0, 0,0)); tbl.push_back(r(0,1,0, 0,0, 0,0));
        tbl.push_back(r(0,1,0, 0,1, 0,0)); tbl.push_back(r(1,1,0, 0,1, 0,0));
        tbl.push_back(r(0,1,0, 0,1, 0,0)); tbl.push_back(r(0,1,0, 0,2, 0,0));
        tbl.push_back(r(1,1,0, 0,2, 0,0)); tbl.push_back(r(0,1,0, 0,2, 0,0));
        tbl.push_back(r(0,1,0, 0,3, 0,0)); tbl.push_back(r(1,1,0, 0,3, 0,0));
        tbl.push_back(r(0,1,0, 0,3, 0,0)); tbl.push_back(r(0,1,0, 0,4, 0,0));
        tbl.push_back(r(0,1,0, 1,0, 0,0));
        // Code 2 gives credit 3, code 3 lifts it to 8, two conversions follow.
        tbl.push_back(r(1,2,0, 1,0, 0,0)); tbl.push_back(r(0,2,0, 1,0, 0,0));
        tbl.push_back(r(0,2,0, 1,3, 0,0)); tbl.push_back(r(1,3,0, 1,3, 0,0));
        tbl.push_back(r(0,3,0, 1,3, 0,0)); tbl.push_back(r(0,3,0, 1,8, 0,0));
        tbl.push_back(r(0,3,0, 2,4, 0,0)); tbl.push_back(r(0,3,0, 3,0, 0,0));
        tbl.push_back(r(0,3,0, 3,0, 0,0));
        // Fill to MAX_GAMES, accumulate to 14, clip at 15.
        tbl.push_back(r(1,3,0, 3,0, 0,0)); tbl.push_back(r(0,3,0, 3,0, 0,0));
        tbl.push_back(r(0,3,0, 3,5, 0,0)); tbl.push_back(r(1,3,0, 4,1, 0,0));
        tbl.push_back(r(0,3,0, 4,1, 0,0)); tbl.push_back(r(0,3,0, 4,6, 0,0));
        tbl.push_back(r(1,3,0, 5,2, 0,0)); tbl.push_back(r(0,3,0, 5,2, 0,0));
        tbl.push_back(r(0,3,0, 5,7, 0,0)); tbl.push_back(r(1,3,0, 6,3, 0,0));
        tbl.push_back(r(0,3,0, 6,3, 0,0)); tbl.push_back(r(0,3,0, 6,8, 0,0));
        tbl.push_back(r(1,3,0, 7,4, 0,0)); tbl.push_back(r(0,3,0, 7,4, 0,0));
        tbl.push_back(r(0,3,0, 7,9, 0,0)); tbl.push_back(r(1,3,0, 7,9, 0,0));
        tbl.push_back(r(0,3,0, 7,9, 0,0)); tbl.push_back(r(0,3,0, 7,14, 0,0));
        tbl.push_back(r(1,3,0, 7,14, 0,0)); tbl.push_back(r(0,3,0, 7,14, 0,0));
        tbl.push_back(r(0,3,0, 7,15, 0,1)); tbl.push_back(r(0,3,0, 7,15, 0,0));
        // Take at the ceiling, then conversion resumes.
        tbl.push_back(r(0,3,1, 6,15, 1,0)); tbl.push_back(r(0,3,0, 7,11, 0,0));
        // Drain to 2 games while conversions interleave with takes.
        tbl.push_back(r(0,3,1, 6,11, 1,0)); tbl.push_back(r(0,3,1, 6,7, 1,0));
        tbl.push_back(r(0,3,1, 6,3, 1,0));  tbl.push_back(r(0,3,1, 5,3, 1,0));
        tbl.push_back(r(0,3,1, 4,3, 1,0));  tbl.push_back(r(0,3,1, 3,3, 1,0));
        tbl.push_back(r(0,3,1, 2,3, 1,0));
        // Credit to 4, then same-cycle conversion and take.
        tbl.push_back(r(1,1,0, 2,3, 0,0)); tbl.push_back(r(0,1,0, 2,3, 0,0));
        tbl.push_back(r(0,1,0, 2,4, 0,0)); tbl.push_back(r(0,1,1, 2,0, 1,0));
        // Requests while not ready are ignored.
        tbl.push_back(mk(0,1,1, 0,0,0, 2,0, 0,0));
        tbl.push_back(mk(0,1,1, 1,1,0, 2,0, 0,0));
        tbl.push_back(r(0,1,0, 2,0, 0,0));

        reset = 1'b1; CoinInserted = 1'b0; CoinValue = 2'd0; startGameNow = 1'b0;
        masterLoaded = 1'b1; gamePlaying = 1'b0;
`ifdef COIN_REFUND_EN
        refundReq = 1'b0;
`endif
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        chk_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i));

        // Reset asserted during a two-game conversion with a new coin in the sync pipe.
        apply(r(1,2,0, 2,0, 0,0), "rst_a0"); apply(r(0,2,0, 2,0, 0,0), "rst_a1");
        apply(r(0,2,0, 2,3, 0,0), "rst_a2"); apply(r(1,3,0, 2,3, 0,0), "rst_a3");
        apply(r(0,3,0, 2,3, 0,0), "rst_a4"); apply(r(0,3,0, 2,8, 0,0), "rst_a5");
        apply(r(1,3,0, 3,4, 0,0), "rst_a6");
        CoinInserted = 1'b0;
        reset = 1'b1;
        #2;
        chk_zero("midreset");
        @(negedge CLOCK_50);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) apply(r(0,3,0, 0,0, 0,0), $sformatf("post_rst%0d", i));

`ifdef COIN_REFUND_EN
        // Refund with credit 3 coinciding with a code-2 coin event.
        apply(r(1,2,0, 0,0, 0,0), "rf0"); apply(r(0,2,0, 0,0, 0,0), "rf1");
        apply(r(0,2,0, 0,3, 0,0), "rf2"); apply(r(1,2,0, 0,3, 0,0), "rf3");
        apply(r(0,2,0, 0,3, 0,0), "rf4");
        apply(mk(0,2,0, 1,0,1, 0,3, 0,0), "rf5");
        chk("rf5.refundValid", int'(refundValid), 1);
        chk("rf5.refundAmt",   int'(refundAmt),   3);
        apply(r(0,2,0, 0,3, 0,0), "rf6");
        chk("rf6.refundValid", int'(refundValid), 0);
        chk("rf6.refundAmt",   int'(refundAmt),   3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
